instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main control unit.
- Holds the PC and issues word requests to instruction memory, waiting on a variable-latency ready handshake.
- Presents the fetched instruction and its 7-bit opcode to the decoder.
- Computes the next PC from the branch/jump/zero feedback of the execute path and counts retired instructions.

Parameters:
- XLEN, 64, width of PC, immediate and retired-instruction counter.
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction word presented when nothing valid is held (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  XLEN  byte address of the requested word; equals pc.
- imem_rdata  input  32  instruction word from memory, sampled when imem_req and imem_ready are both 1.
- imem_ready  input  1  memory has valid data this cycle; ignored when imem_req=0.
- stall  input  1  downstream hold; instruction is not retired while 1.
- branch  input  1  current instruction is a conditional branch (from control unit).
- zero  input  1  ALU zero flag for the current instruction.
- jump  input  1  current instruction is jal.
- halt  input  1  current instruction is ecall/ebreak.
- imm  input  XLEN  sign-extended byte offset for branch/jump target.
- pc  output  XLEN  address of the instruction held in instr.
- instr  output  32  held instruction word.
- opcode  output  7  instr[6:0]; feeds the control unit.
- instr_valid  output  1  instr holds a fetched, unretired instruction.
- halted  output  1  fetch stopped by halt.
- instret  output  XLEN  count of retired instructions.

Behaviour:
- FSM states: REQ, EXEC, HALTED.
- Reset (async, any state, including mid-request):
  - state=REQ, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, halted=0, instret=0.
  - imem_req is forced 0 while rst=1.
- REQ:
  - imem_req=1, imem_addr=pc, instr_valid=0, opcode=instr[6:0] of the held NOP.
  - While imem_ready=0, stay in REQ; imem_req and imem_addr stay stable (wait states of any length are allowed).
  - On an edge with imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to EXEC.
  - A zero-wait memory gives 2 cycles per instruction.
- EXEC:
  - imem_req=0, instr_valid=1.
  - branch, zero, jump, halt and imm are sampled only in EXEC on an edge where stall=0 (retire edge).
  - stall=1: hold all state; inputs are ignored.
  - On a retire edge, instret<=instret+1 (wraps modulo 2^XLEN), and the next action is chosen by priority:
    - halt=1: go to HALTED; pc unchanged.
    - else jump=1: pc<=pc+imm.
    - else branch=1 and zero=1: pc<=pc+imm.
    - else: pc<=pc+4.
  - Then go to REQ, with instr<=NOP_INSTR and instr_valid<=0.
- PC arithmetic:
  - Unsigned add modulo 2^XLEN (wrap-around, no trap).
  - Target bits [1:0] are forced to 0.
  - jump and branch both 1: jump wins (same target).
- HALTED:
  - halted=1, imem_req=0, instr_valid=0, instr=NOP_INSTR.
  - pc keeps the address of the halting instruction; instret includes that instruction.
  - Leaves only on reset.
- Outputs:
  - opcode is always instr[6:0] (combinational).
  - pc, instr, instr_valid and instret are registered.

Test Plan:
- Reset then zero-wait memory returning 0x00000033 at each word -> pc steps 0,4,8,C; instr_valid high every 2nd cycle; after 4 retires, instret=4; opcode=7'h33.
- In EXEC at pc=0x10, imm=-8 (all ones ...FFF8), branch=1 with zero=1 -> next imem_addr=0x08. Repeat with zero=0 -> next imem_addr=0x14.
- jump=1 with imm=0x100 at pc=0x20 -> next imem_addr=0x120. At pc=2^XLEN-4 with no branch -> pc wraps to 0.
- Memory with 3 wait states plus stall=1 held 5 cycles in EXEC -> imem_addr stable through the waits; pc, instr and instret frozen during stall; a single retire after stall drops.
- halt=1 on a retire edge at pc=0x40 -> halted=1, imem_req stays 0 for 20+ cycles, pc=0x40, instret incremented once.
- rst asserted mid-REQ with imem_ready=0, then released -> asynchronous clear to pc=RESET_PC, instret=0, instr=0x00000013; the first request after release goes to RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches words over a ready handshake,
// presents the instruction to the decoder, and retires it on a non-stalled EXEC edge.
module instr_fetch_unit #(
    parameter int unsigned           XLEN      = 64,
    parameter logic [XLEN-1:0]       RESET_PC  = '0,
    parameter logic [31:0]           NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    input  logic            stall,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic            halt,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic            instr_valid,
    output logic            halted,
    output logic [XLEN-1:0] instret
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_valid;
    logic            r_halted;
    logic [XLEN-1:0] r_instret;

    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_target;
    logic            w_take;
    logic [XLEN-1:0] w_next_pc;

    // Branch/jump targets are word-aligned by clearing the low two bits.
    assign w_sum     = r_pc + imm;
    assign w_target  = {w_sum[XLEN-1:2], 2'b00};
    assign w_take    = jump || (branch && zero);
    assign w_next_pc = w_take ? w_target : (r_pc + XLEN'(4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
            r_instret <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        r_instret <= r_instret + XLEN'(1);
                        r_instr   <= NOP_INSTR;
                        r_valid   <= 1'b0;
                        if (halt) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALTED;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_HALTED: begin
                    r_state <= S_HALTED;
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    // Request is derived from state so it is live the first cycle after reset release.
    assign imem_req    = (r_state == S_REQ) && !rst;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[6:0];
    assign instr_valid = r_valid;
    assign halted      = r_halted;
    assign instret     = r_instret;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetch/retire traffic against a transaction-level PC/instret model.
module tb_instr_fetch_unit;

    localparam int unsigned  XLEN = 64;
    localparam logic [63:0]  RPC  = 64'h0;
    localparam logic [31:0]  NOP  = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [63:0]     imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ready;
    logic            stall;
    logic            branch;
    logic            zero;
    logic            jump;
    logic            halt;
    logic [63:0]     imm;
    logic [63:0]     pc;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic            instr_valid;
    logic            halted;
    logic [63:0]     instret;

    instr_fetch_unit #(
        .XLEN      (XLEN),
        .RESET_PC  (RPC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .halt        (halt),
        .imm         (imm),
        .pc          (pc),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .halted      (halted),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_pc;
    logic [63:0] m_cnt;
    logic        m_halted;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall  = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
        jump   = 1'b0;
        halt   = 1'b0;
        imm    = '0;
    endtask

    task automatic model_reset();
        m_pc     = RPC;
        m_cnt    = '0;
        m_halted = 1'b0;
    endtask

    // One full fetch/execute/retire transaction with the given memory latency and stall length.
    task automatic do_instr(input logic [31:0] w, input int waits, input int stalls,
                            input logic br, input logic z, input logic j, input logic h,
                            input logic [63:0] im);
        logic [63:0] sum;
        check("req_phase_req", {63'd0, imem_req}, 64'd1);
        check("req_phase_addr", imem_addr, m_pc);
        check("req_phase_valid", {63'd0, instr_valid}, 64'd0);
        check("req_phase_opcode", {57'd0, opcode}, {57'd0, NOP[6:0]});
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            tick();
            check("wait_req", {63'd0, imem_req}, 64'd1);
            check("wait_addr", imem_addr, m_pc);
            check("wait_valid", {63'd0, instr_valid}, 64'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = w;
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check("exec_valid", {63'd0, instr_valid}, 64'd1);
        check("exec_instr", {32'd0, instr}, {32'd0, w});
        check("exec_opcode", {57'd0, opcode}, {57'd0, w[6:0]});
        check("exec_pc", pc, m_pc);
        check("exec_req", {63'd0, imem_req}, 64'd0);
        for (int i = 0; i < stalls; i++) begin
            stall  = 1'b1;
            branch = 1'($urandom);
            zero   = 1'($urandom);
            jump   = 1'($urandom);
            halt   = 1'($urandom);
            imm    = {$urandom, $urandom};
            tick();
            check("stall_pc", pc, m_pc);
            check("stall_instr", {32'd0, instr}, {32'd0, w});
            check("stall_instret", instret, m_cnt);
            check("stall_valid", {63'd0, instr_valid}, 64'd1);
            check("stall_halted", {63'd0, halted}, 64'd0);
        end
        stall  = 1'b0;
        branch = br;
        zero   = z;
        jump   = j;
        halt   = h;
        imm    = im;
        tick();
        clear_ctrl();
        m_cnt = m_cnt + 64'd1;
        if (h) begin
            m_halted = 1'b1;
        end else if (j || (br && z)) begin
            sum  = m_pc + im;
            m_pc = sum & ~64'h3;
        end else begin
            m_pc = m_pc + 64'd4;
        end
        check("retire_instret", instret, m_cnt);
        check("retire_halted", {63'd0, halted}, {63'd0, m_halted});
        check("retire_pc", pc, m_pc);
        check("retire_instr", {32'd0, instr}, {32'd0, NOP});
    endtask

    initial begin
        logic [31:0] rw;
        logic [11:0] rs;
        logic [63:0] rimm;
        logic        rj;
        rst        = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = '0;
        clear_ctrl();
        model_reset();
        tick();
        tick();
        check("rst_req", {63'd0, imem_req}, 64'd0);
        check("rst_pc", pc, RPC);
        check("rst_instr", {32'd0, instr}, {32'd0, NOP});
        check("rst_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_instret", instret, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Zero-wait memory, straight-line code.
        for (int k = 0; k < 4; k++)
            do_instr(32'h0000_0033, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        check("seq_instret4", instret, 64'd4);
        check("seq_pc", pc, 64'h10);

        // Branch taken/not taken with negative offset.
        do_instr(32'h0000_0063, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8);
        check("br_taken_addr", imem_addr, 64'h08);
        do_instr(32'h0000_006F, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h8);
        do_instr(32'h0000_0063, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8);
        check("br_not_taken_addr", imem_addr, 64'h14);

        // Jump, then wrap past the top of the address space.
        do_instr(32'h0000_006F, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64'hC);
        do_instr(32'h0000_006F, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h100);
        check("jump_addr", imem_addr, 64'h120);
        do_instr(32'h0000_006F, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC - 64'h120);
        check("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        do_instr(32'h0000_0033, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        check("wrap_addr", imem_addr, 64'h0);

        // Unaligned offset is aligned down.
        do_instr(32'h0000_006F, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h23);
        check("align_addr", imem_addr, 64'h20);

        // Slow memory plus a long stall.
        do_instr(32'hDEAD_BEB3, 3, 5, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

        // Randomized traffic.
        for (int k = 0; k < 80; k++) begin
            rw = $urandom;
            rs = 12'($urandom);
            rimm = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : {{52{rs[11]}}, rs};
            rj = ($urandom_range(0, 3) == 0);
            do_instr(rw, $urandom_range(0, 3), $urandom_range(0, 2),
                     1'($urandom), 1'($urandom), rj, 1'b0, rimm);
        end

        // Halt at 0x40.
        do_instr(32'h0000_006F, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h40 - m_pc);
        check("pre_halt_addr", imem_addr, 64'h40);
        do_instr(32'h0000_0073, 2, 1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h100);
        for (int i = 0; i < 22; i++) begin
            imem_ready = 1'($urandom);
            tick();
            check("halt_req", {63'd0, imem_req}, 64'd0);
            check("halt_valid", {63'd0, instr_valid}, 64'd0);
        end
        imem_ready = 1'b0;
        check("halt_pc", pc, 64'h40);
        check("halt_flag", {63'd0, halted}, 64'd1);
        check("halt_instret", instret, m_cnt);
        check("halt_instr", {32'd0, instr}, {32'd0, NOP});

        // Leave HALTED via reset, then reset asynchronously mid-request.
        #2;
        rst = 1'b1;
        #1;
        check("halt_rst_flag", {63'd0, halted}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick();
        do_instr(32'h0000_0033, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h200);
        imem_ready = 1'b0;
        tick();
        tick();
        check("midreq_addr", imem_addr, 64'h200);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", pc, RPC);
        check("arst_instret", instret, 64'd0);
        check("arst_instr", {32'd0, instr}, {32'd0, NOP});
        check("arst_req", {63'd0, imem_req}, 64'd0);
        check("arst_valid", {63'd0, instr_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("post_rst_req", {63'd0, imem_req}, 64'd1);
        check("post_rst_addr", imem_addr, RPC);
        tick();
        do_instr(32'h0000_0013, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        check("post_rst_instret", instret, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
